obj_table_sync_ctrl: RTL and testbench

Clocked controller that sequences the three-phase software-to-hardware object-table transfer: phase 1 carries X, phase 2 carries Y, phase 3 carries state and type. It replaces level-latched capture with a filtered, order-checked 4-phase handshake into a shadow table. The shadow table is committed to the active table only on a VGA frame_start pulse, so the sprite renderer never sees a half-updated frame. It sits between the CPU PIO ports and the sprite/draw logic.

---
 rtl/hw_sw_comm_pkg.sv | 35 +++
 rtl/hs_code_filter.sv | 47 ++++
 rtl/obj_table_sync_ctrl.sv | 168 ++++++++++++++++
 tb/tb_obj_table_sync_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hw_sw_comm_pkg.sv
// Shared types and constants for the software-to-hardware object-table handshake.
// Lane layout: each object owns a 32-bit lane of the PIO port bus.
package hw_sw_comm_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_X    = 2'd1,
    PH_Y    = 2'd2,
    PH_ST   = 2'd3
  } phase_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CAP_X,
    S_ACK_X,
    S_WAIT_Y,
    S_CAP_Y,
    S_ACK_Y,
    S_WAIT_ST,
    S_CAP_ST,
    S_ACK_ST
  } sync_state_e;

  localparam int DEF_N_OBJ   = 15;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_Y_FLIP  = 480;

  localparam int LANE_W = 32;
  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 0;
  localparam int ST_LSB = 0;
  localparam int TY_LSB = 3;
  localparam int ST_W   = 3;

endpackage

// File: rtl/hs_code_filter.sv
// Debounces the software phase code: a code is accepted only after it has
// been sampled unchanged for STABLE_CYCLES consecutive clocks.
module hs_code_filter
  import hw_sw_comm_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] code_in,
  output phase_e     code_acc
);

  localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [1:0]       sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           acc_q, acc_d;

  always_comb begin
    sample_d = code_in;
    acc_d    = acc_q;
    if (code_in == sample_q)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    else
      cnt_d = CNT_W'(1);
    if (cnt_d == CNT_MAX)
      acc_d = phase_e'(code_in);
  end

  // NOTE: sequential state uses non-blocking assignments only, with the async active-low reset in the sensitivity list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= 2'd0;
      cnt_q    <= '0;
      acc_q    <= PH_IDLE;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign code_acc = acc_q;

endmodule

// File: rtl/obj_table_sync_ctrl.sv
// Three-phase object-table transfer into a shadow table, committed to the
// active table only on frame_start so the renderer never sees a torn frame.
module obj_table_sync_ctrl
  import hw_sw_comm_pkg::*;
#(
  parameter int N_OBJ         = DEF_N_OBJ,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int Y_FLIP        = DEF_Y_FLIP,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               to_hw_sig,
  input  logic [32*N_OBJ-1:0]      port_bus,
  input  logic                     frame_start,
  output logic [1:0]               to_sw_sig,
  output logic [COORD_W*N_OBJ-1:0] xcoord_bus,
  output logic [COORD_W*N_OBJ-1:0] ycoord_bus,
  output logic [3*N_OBJ-1:0]       state_bus,
  output logic [3*N_OBJ-1:0]       type_bus,
  output logic                     table_valid,
  output logic                     frame_pending,
  output logic                     seq_err,
  output logic [7:0]               commit_count
);

  typedef logic [N_OBJ-1:0][COORD_W-1:0] coord_tbl_t;
  typedef logic [N_OBJ-1:0][ST_W-1:0]    attr_tbl_t;

  phase_e      acc;
  sync_state_e state_q, state_d;
  phase_e      to_sw_q, to_sw_d;
  coord_tbl_t  sh_x_q, sh_x_d, sh_y_q, sh_y_d, act_x_q, act_x_d, act_y_q, act_y_d;
  attr_tbl_t   sh_st_q, sh_st_d, sh_ty_q, sh_ty_d, act_st_q, act_st_d, act_ty_q, act_ty_d;
  logic        valid_q, valid_d, pend_q, pend_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  hs_code_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk      (clk),
    .reset    (reset),
    .code_in  (to_hw_sig),
    .code_acc (acc)
  );

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    to_sw_d  = to_sw_q;
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_st_d  = sh_st_q;
    sh_ty_d  = sh_ty_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    act_st_d = act_st_q;
    act_ty_d = act_ty_q;
    valid_d  = valid_q;
    pend_d   = pend_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (acc == PH_X && !pend_q) state_d = S_CAP_X;
        else if (acc == PH_Y || acc == PH_ST) err_d = 1'b1;
      end
      S_CAP_X: begin
        for (int i = 0; i < N_OBJ; i++)
          sh_x_d[i] = port_bus[LANE_W*i + X_LSB +: COORD_W];
        to_sw_d = PH_X;
        err_d   = 1'b0;
        state_d = S_ACK_X;
      end
      S_CAP_Y: begin
        for (int i = 0; i < N_OBJ; i++)
          sh_y_d[i] = COORD_W'(Y_FLIP) - port_bus[LANE_W*i + Y_LSB +: COORD_W];
        to_sw_d = PH_Y;
        state_d = S_ACK_Y;
      end
      S_CAP_ST: begin
        for (int i = 0; i < N_OBJ; i++) begin
          sh_st_d[i] = port_bus[LANE_W*i + ST_LSB +: ST_W];
          sh_ty_d[i] = port_bus[LANE_W*i + TY_LSB +: ST_W];
        end
        to_sw_d = PH_ST;
        state_d = S_ACK_ST;
      end
      S_ACK_X, S_ACK_Y, S_ACK_ST: begin
        if (acc == PH_IDLE) begin
          to_sw_d = PH_IDLE;
          if (state_q == S_ACK_X)      state_d = S_WAIT_Y;
          else if (state_q == S_ACK_Y) state_d = S_WAIT_ST;
          else begin
            pend_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_Y, S_WAIT_ST: begin
        if (state_q == S_WAIT_Y && acc == PH_Y)        state_d = S_CAP_Y;
        else if (state_q == S_WAIT_ST && acc == PH_ST) state_d = S_CAP_ST;
        else if (acc != PH_IDLE) begin
          err_d   = 1'b1;
          to_sw_d = PH_IDLE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Commit uses the registered pending flag, so a release landing on frame_start waits a frame.
    if (frame_start && pend_q) begin
      act_x_d  = sh_x_q;
      act_y_d  = sh_y_q;
      act_st_d = sh_st_q;
      act_ty_d = sh_ty_q;
      pend_d   = 1'b0;
      valid_d  = 1'b1;
      cnt_d    = cnt_q + 8'd1;
    end
  end

  // NOTE: the shadow and active tables are flops, not RAM, so they take the async reset like the rest of the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      to_sw_q  <= PH_IDLE;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_st_q  <= '0;
      sh_ty_q  <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      act_st_q <= '0;
      act_ty_q <= '0;
      valid_q  <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      to_sw_q  <= to_sw_d;
      sh_x_q   <= sh_x_d;
      sh_y_q   <= sh_y_d;
      sh_st_q  <= sh_st_d;
      sh_ty_q  <= sh_ty_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      act_st_q <= act_st_d;
      act_ty_q <= act_ty_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign to_sw_sig     = to_sw_q;
  assign xcoord_bus    = act_x_q;
  assign ycoord_bus    = act_y_q;
  assign state_bus     = act_st_q;
  assign type_bus      = act_ty_q;
  assign table_valid   = valid_q;
  assign frame_pending = pend_q;
  assign seq_err       = err_q;
  assign commit_count  = cnt_q;

endmodule

// File: tb/tb_obj_table_sync_ctrl.sv
// Directed bench for obj_table_sync_ctrl: full transfer, glitch filter,
// order error, backpressure, Y wrap, coincident frame_start and mid-transfer reset.
module tb_obj_table_sync_ctrl;

  localparam int N_OBJ   = 15;
  localparam int COORD_W = 10;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [1:0]               to_hw_sig;
  logic [32*N_OBJ-1:0]      port_bus;
  logic                     frame_start;
  logic [1:0]               to_sw_sig;
  logic [COORD_W*N_OBJ-1:0] xcoord_bus;
  logic [COORD_W*N_OBJ-1:0] ycoord_bus;
  logic [3*N_OBJ-1:0]       state_bus;
  logic [3*N_OBJ-1:0]       type_bus;
  logic                     table_valid;
  logic                     frame_pending;
  logic                     seq_err;
  logic [7:0]               commit_count;

  int errors = 0;
  int checks = 0;

  obj_table_sync_ctrl #(.N_OBJ(N_OBJ), .COORD_W(COORD_W), .Y_FLIP(480), .STABLE_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .to_hw_sig     (to_hw_sig),
    .port_bus      (port_bus),
    .frame_start   (frame_start),
    .to_sw_sig     (to_sw_sig),
    .xcoord_bus    (xcoord_bus),
    .ycoord_bus    (ycoord_bus),
    .state_bus     (state_bus),
    .type_bus      (type_bus),
    .table_valid   (table_valid),
    .frame_pending (frame_pending),
    .seq_err       (seq_err),
    .commit_count  (commit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic hold(input logic [1:0] code, input int n);
    to_hw_sig = code;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic check_active(input string tag, input int lane, input int x, input int y,
                              input int st, input int ty);
    check({tag, "_x"},  32'(xcoord_bus[lane*COORD_W +: COORD_W]), 32'(x));
    check({tag, "_y"},  32'(ycoord_bus[lane*COORD_W +: COORD_W]), 32'(y));
    check({tag, "_st"}, 32'(state_bus[lane*3 +: 3]), 32'(st));
    check({tag, "_ty"}, 32'(type_bus[lane*3 +: 3]), 32'(ty));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_to_sw"}, 32'(to_sw_sig), 0);
    check({tag, "_x"},     32'(|xcoord_bus), 0);
    check({tag, "_y"},     32'(|ycoord_bus), 0);
    check({tag, "_st"},    32'(|state_bus), 0);
    check({tag, "_ty"},    32'(|type_bus), 0);
    check({tag, "_valid"}, 32'(table_valid), 0);
    check({tag, "_pend"},  32'(frame_pending), 0);
    check({tag, "_err"},   32'(seq_err), 0);
    check({tag, "_count"}, 32'(commit_count), 0);
  endtask

  initial begin
    int waited;
    reset       = 1'b0;
    to_hw_sig   = 2'd0;
    port_bus    = '0;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Single-cycle glitch of code 1 is filtered out
    hold(2'd1, 1);
    hold(2'd0, 6);
    check("glitch_to_sw", 32'(to_sw_sig), 0);
    check("glitch_pend", 32'(frame_pending), 0);

    // Full transfer, lane 0 and lane 14
    port_bus[31:0] = 32'd100;
    port_bus[14*32 +: 32] = 32'd1023;
    hold(2'd1, 4); check("full_ack1", 32'(to_sw_sig), 1);
    hold(2'd0, 4); check("full_rel1", 32'(to_sw_sig), 0);
    port_bus[31:0] = 32'd80;
    port_bus[14*32 +: 32] = 32'd0;
    hold(2'd2, 4); check("full_ack2", 32'(to_sw_sig), 2);
    hold(2'd0, 4); check("full_rel2", 32'(to_sw_sig), 0);
    port_bus[31:0] = 32'd42;            // type 5, state 2
    port_bus[14*32 +: 32] = 32'd15;     // type 1, state 7
    hold(2'd3, 4); check("full_ack3", 32'(to_sw_sig), 3);
    hold(2'd0, 4); check("full_rel3", 32'(to_sw_sig), 0);
    check("full_pend", 32'(frame_pending), 1);
    check("full_precommit_x", 32'(xcoord_bus[9:0]), 0);
    check("full_precommit_valid", 32'(table_valid), 0);
    pulse_frame();
    check_active("full_l0", 0, 100, 400, 2, 5);
    check_active("full_l14", 14, 1023, 480, 7, 1);
    check("full_valid", 32'(table_valid), 1);
    check("full_count", 32'(commit_count), 1);
    check("full_pend_clr", 32'(frame_pending), 0);

    // frame_start with nothing pending
    hold(2'd0, 2);
    pulse_frame();
    check("idle_frame_count", 32'(commit_count), 1);
    check("idle_frame_x", 32'(xcoord_bus[9:0]), 100);

    // Out-of-order phase 3 while waiting for phase 2
    port_bus[31:0] = 32'd200;
    hold(2'd1, 4);
    hold(2'd0, 4);
    hold(2'd3, 4);
    check("ooo_err", 32'(seq_err), 1);
    check("ooo_to_sw", 32'(to_sw_sig), 0);
    check("ooo_pend", 32'(frame_pending), 0);
    hold(2'd0, 4);
    port_bus[31:0] = 32'd300;
    hold(2'd1, 4);
    check("ooo_recover_ack", 32'(to_sw_sig), 1);
    check("ooo_recover_err", 32'(seq_err), 0);

    // Complete with Y=500 (wraps), then backpressure on phase 1
    hold(2'd0, 4);
    port_bus[31:0] = 32'd500;
    hold(2'd2, 4);
    hold(2'd0, 4);
    port_bus[31:0] = 32'd11;            // type 1, state 3
    hold(2'd3, 4);
    hold(2'd0, 4);
    check("bp_pend", 32'(frame_pending), 1);
    port_bus[31:0] = 32'd777;
    hold(2'd1, 20);
    check("bp_to_sw", 32'(to_sw_sig), 0);
    check("bp_count", 32'(commit_count), 1);
    pulse_frame();
    check_active("bp_commit", 0, 300, 1004, 3, 1);
    check("bp_commit_count", 32'(commit_count), 2);
    waited = 0;
    while (to_sw_sig !== 2'd1 && waited < 3) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("bp_ack_after_commit", 32'(to_sw_sig), 1);

    // frame_start coincident with the ACK_ST release edge
    hold(2'd0, 4);
    port_bus[31:0] = 32'd10;
    hold(2'd2, 4);
    hold(2'd0, 4);
    port_bus[31:0] = 32'd25;            // type 3, state 1
    hold(2'd3, 4);
    hold(2'd0, 2);                      // code 0 accepted; next edge leaves ACK_ST
    pulse_frame();
    check("coinc_pend", 32'(frame_pending), 1);
    check("coinc_count", 32'(commit_count), 2);
    check("coinc_x", 32'(xcoord_bus[9:0]), 300);
    hold(2'd0, 1);
    pulse_frame();
    check_active("coinc_commit", 0, 777, 470, 1, 3);
    check("coinc_commit_count", 32'(commit_count), 3);

    // Async reset while in ACK_Y
    port_bus[31:0] = 32'd55;
    hold(2'd1, 4);
    hold(2'd0, 4);
    hold(2'd2, 4);
    check("rst_pre_ack2", 32'(to_sw_sig), 2);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    to_hw_sig = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    port_bus[31:0] = 32'd12;
    hold(2'd1, 4);
    hold(2'd0, 4);
    port_bus[31:0] = 32'd479;
    hold(2'd2, 4);
    hold(2'd0, 4);
    port_bus[31:0] = 32'd56;            // type 7, state 0
    hold(2'd3, 4);
    hold(2'd0, 4);
    pulse_frame();
    check_active("post_rst", 0, 12, 1, 0, 7);
    check("post_rst_count", 32'(commit_count), 1);
    check("post_rst_valid", 32'(table_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
